// File: rtl/pwm_tick_generator_if.sv
// Load port for the PWM generator: period/duty setting offered under valid/ready.
// The master drives the setting and load_valid; the slave returns load_ready.
interface pwm_tick_generator_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] duty;
    logic             load_valid;
    logic             load_ready;

    modport master (
        output period,
        output duty,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  period,
        input  duty,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/pwm_tick_generator.sv
// Tick-driven PWM with a double-buffered period/duty setting applied only at cycle boundaries.
// Latency: pwm_out updates on the edge that accepts a tick; cycle_start follows its starting edge.
// Backpressure: load_ready drops on accept and returns the edge after the setting is applied.
module pwm_tick_generator #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 enable,
    pwm_tick_generator_if.slave  load_if,
    output logic                 pwm_out,
    output logic                 cycle_start
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] active_period;
    logic [WIDTH-1:0] active_duty;
    logic [WIDTH-1:0] pend_period;
    logic [WIDTH-1:0] pend_duty;
    logic             pend_valid;
    logic [WIDTH-1:0] pos;
    logic             load_ready_q;

    logic             load_accept;
    logic             tick_accept;
    logic             wrap;
    logic [WIDTH-1:0] pos_inc;
    logic [WIDTH-1:0] eff_period;
    logic [WIDTH-1:0] eff_duty;

    assign load_if.load_ready = load_ready_q;

    assign load_accept = load_if.load_valid && load_ready_q;
    assign tick_accept = tick && enable;
    assign wrap        = (pos == (active_period - WIDTH'(1)));
    assign pos_inc     = pos + WIDTH'(1);
    // At a wrap the pending setting, if any, governs the cycle that begins on that edge.
    assign eff_period  = pend_valid ? pend_period : active_period;
    assign eff_duty    = pend_valid ? pend_duty   : active_duty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            active_period <= '0;
            active_duty   <= '0;
            pend_period   <= '0;
            pend_duty     <= '0;
            pend_valid    <= 1'b0;
            pos           <= '0;
            pwm_out       <= 1'b0;
            cycle_start   <= 1'b0;
            load_ready_q  <= 1'b1;
        end else begin
            cycle_start <= 1'b0;

            // Ready is low from accept until one edge after the pending setting is consumed.
            if (!load_ready_q && !pend_valid) begin
                load_ready_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    pwm_out <= 1'b0;
                    pos     <= '0;
                    if (pend_valid) begin
                        active_period <= pend_period;
                        active_duty   <= pend_duty;
                        pend_valid    <= 1'b0;
                        if (pend_period != '0) begin
                            state       <= RUN;
                            pwm_out     <= (pend_duty != '0);
                            cycle_start <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (tick_accept) begin
                        if (wrap) begin
                            pos         <= '0;
                            cycle_start <= 1'b1;
                            if (pend_valid) begin
                                active_period <= pend_period;
                                active_duty   <= pend_duty;
                                pend_valid    <= 1'b0;
                            end
                            if (eff_period == '0) begin
                                state   <= IDLE;
                                pwm_out <= 1'b0;
                            end else begin
                                pwm_out <= (eff_duty != '0);
                            end
                        end else begin
                            pos     <= pos_inc;
                            pwm_out <= (pos_inc < active_duty);
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    pwm_out <= 1'b0;
                end
            endcase

            // Accept never coincides with an apply: ready high implies nothing is pending.
            if (load_accept) begin
                pend_period  <= load_if.period;
                pend_duty    <= load_if.duty;
                pend_valid   <= 1'b1;
                load_ready_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_tick_generator.sv
// Directed bench for pwm_tick_generator with a cycle-level reference model.
module tb_pwm_tick_generator;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    logic tick;
    logic enable;
    logic pwm_out;
    logic cycle_start;

    pwm_tick_generator_if #(.WIDTH(W)) ld_if ();

    pwm_tick_generator #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .enable      (enable),
        .load_if     (ld_if),
        .pwm_out     (pwm_out),
        .cycle_start (cycle_start)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k counts ticks elapsed in the current PWM cycle; the output is
    // high while k is below min(duty, period).
    bit m_run, m_pend, m_ready, m_cs;
    int m_per, m_duty, m_k, m_pper, m_pduty;

    always @(posedge clk or posedge rst) begin
        bit acc;
        bit applied;
        if (rst) begin
            m_run = 0; m_pend = 0; m_ready = 1; m_cs = 0;
            m_per = 0; m_duty = 0; m_k = 0; m_pper = 0; m_pduty = 0;
        end else begin
            acc     = ld_if.load_valid && m_ready;
            applied = 0;
            m_cs    = 0;
            if (!m_run) begin
                if (m_pend) begin
                    m_per = m_pper; m_duty = m_pduty; m_pend = 0; applied = 1;
                    if (m_per != 0) begin
                        m_run = 1; m_k = 0; m_cs = 1;
                    end
                end
            end else if (tick && enable) begin
                m_k = m_k + 1;
                if (m_k == m_per) begin
                    m_k = 0; m_cs = 1;
                    if (m_pend) begin
                        m_per = m_pper; m_duty = m_pduty; m_pend = 0; applied = 1;
                    end
                    if (m_per == 0) m_run = 0;
                end
            end
            if (acc) begin
                m_pend = 1; m_pper = int'(ld_if.period); m_pduty = int'(ld_if.duty);
            end
            m_ready = !m_pend && !applied;
        end
    end

    function automatic logic model_pwm();
        int hi;
        hi = (m_duty < m_per) ? m_duty : m_per;
        return m_run && (m_k < hi);
    endfunction

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("model_pwm_out", pwm_out, model_pwm());
            check("model_cycle_start", cycle_start, m_cs);
            check("model_load_ready", ld_if.load_ready, m_ready);
        end
    end

    // Issue ticks spaced 'gap' clocks apart; record pwm_out after each tick and count cycle_start pulses.
    task automatic tick_n(input int n, input int gap, output logic [31:0] pw, output int cs_cnt);
        pw = '0;
        cs_cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            pw[i] = pwm_out;
            if (cycle_start) cs_cnt++;
            for (int j = 0; j < gap - 1; j++) begin
                @(negedge clk);
                if (cycle_start) cs_cnt++;
            end
        end
    endtask

    task automatic do_load(input int p, input int d);
        int b;
        b = 0;
        while (!ld_if.load_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("load_ready_wait", ld_if.load_ready, 1);
        ld_if.period     = W'(p);
        ld_if.duty       = W'(d);
        ld_if.load_valid = 1'b1;
        @(negedge clk);
        ld_if.load_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] pw;
    int          cs;

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        enable = 1'b1;
        ld_if.load_valid = 1'b0;
        ld_if.period = '0;
        ld_if.duty = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_pwm_out", pwm_out, 0);
        check("reset_cycle_start", cycle_start, 0);
        check("reset_load_ready", ld_if.load_ready, 1);

        // 5/2 start-up from IDLE
        do_load(5, 2);
        check("t1_ready_after_accept", ld_if.load_ready, 0);
        @(negedge clk);
        check("t1_first_cycle_start", cycle_start, 1);
        check("t1_first_pwm", pwm_out, 1);
        check("t1_ready_after_apply", ld_if.load_ready, 0);
        @(negedge clk);
        check("t1_ready_two_clks", ld_if.load_ready, 1);
        check("t1_cs_one_clock", cycle_start, 0);
        tick_n(10, 4, pw, cs);
        check("t1_pattern_5_2", pw[9:0], 10'b1000110001);
        check("t1_cs_count", cs, 2);

        // mid-cycle reload to 3/3
        tick_n(2, 4, pw, cs);
        check("t2_pre_pattern", pw[1:0], 2'b01);
        do_load(3, 3);
        check("t2_ready_low_pending", ld_if.load_ready, 0);
        tick_n(3, 4, pw, cs);
        check("t2_old_cycle_completes", pw[2:0], 3'b100);
        check("t2_wrap_cs", cs, 1);
        check("t2_ready_back", ld_if.load_ready, 1);
        tick_n(6, 4, pw, cs);
        check("t2_constant_high", pw[5:0], 6'b111111);
        check("t2_cs_every_3", cs, 2);

        // duty 0, period 4
        do_load(4, 0);
        tick_n(3, 4, pw, cs);
        check("t3_transition", pw[2:0], 3'b011);
        check("t3_transition_cs", cs, 1);
        tick_n(8, 4, pw, cs);
        check("t3_constant_low", pw[7:0], 8'h00);
        check("t3_cs_every_4", cs, 2);

        // enable freeze mid-cycle
        do_load(5, 2);
        tick_n(4, 4, pw, cs);
        check("t4_apply_5_2", pw[3:0], 4'b1000);
        tick_n(1, 4, pw, cs);
        check("t4_before_freeze", pw[0], 1);
        enable = 1'b0;
        cs = 0;
        for (int i = 0; i < 10; i++) begin
            tick = ~tick;
            @(negedge clk);
            if (cycle_start) cs++;
        end
        tick = 1'b0;
        check("t4_frozen_pwm", pwm_out, 1);
        check("t4_frozen_cs", cs, 0);
        enable = 1'b1;
        tick_n(4, 4, pw, cs);
        check("t4_resume_pattern", pw[3:0], 4'b1000);
        check("t4_resume_cs", cs, 1);

        // period 0 stops at the next wrap
        do_load(0, 0);
        tick_n(5, 4, pw, cs);
        check("t5_last_cycle", pw[4:0], 5'b00001);
        check("t5_last_cs", cs, 1);
        tick_n(10, 4, pw, cs);
        check("t5_idle_pwm", pw[9:0], 10'h000);
        check("t5_idle_cs", cs, 0);

        // async reset with a pending load
        do_load(5, 2);
        @(negedge clk);
        tick_n(2, 4, pw, cs);
        check("t6_running", pw[1:0], 2'b01);
        do_load(3, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_pwm", pwm_out, 0);
        check("t6_rst_cs", cycle_start, 0);
        check("t6_rst_ready", ld_if.load_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick_n(10, 4, pw, cs);
        check("t6_no_stale_pwm", pw[9:0], 10'h000);
        check("t6_no_stale_cs", cs, 0);
        do_load(2, 1);
        @(negedge clk);
        check("t6_new_start_pwm", pwm_out, 1);
        check("t6_new_start_cs", cycle_start, 1);
        tick_n(4, 4, pw, cs);
        check("t6_pattern_2_1", pw[3:0], 4'b1010);
        check("t6_cs_count", cs, 2);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
